// File: rtl/stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fifo_pkg
//  Brief    : Shared constants, pointer-width helper and stream payload type
//             for the stream_fifo elastic buffer and related stream blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package stream_fifo_pkg;

  // Default payload width of a standard stream link.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Pointer width: one address bit per log2(depth) plus a wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Generic stream beat, reused by other stream blocks.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          valid;
  } stream_t;

endpackage
`default_nettype wire

// File: rtl/stream_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fifo_mem
//  Brief    : DEPTH x DATA_WIDTH register file with one write port and one
//             registered read port. Storage is not reset; only the read
//             register is, so the head output is well defined after reset.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write; deliberately no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read with write-through so a word written into the slot being
  // read (push into an empty FIFO) appears on the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fifo
//  Brief    : Registered ready/valid FIFO. Every output is a flop, so no
//             combinational path crosses between the in_a and out_a sides.
//             Optional macro STREAM_FIFO_LEVEL_EN adds a registered 'level'
//             output and protocol assertions.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_a_data,
  input  logic                         in_a_valid,
  output logic                         in_a_ready,
  output logic [DATA_WIDTH-1:0]        out_a_data,
  output logic                         out_a_valid,
  input  logic                         out_a_ready
`ifdef STREAM_FIFO_LEVEL_EN
  ,
  output logic [ptr_width(DEPTH)-1:0]  level
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);
  localparam logic [PW-1:0] ZERO_P  = '0;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next;
  logic [PW-1:0] count, count_next;
  logic          push, pop;
  logic          full, empty;

  // Handshakes, flags and next-state pointer arithmetic.
  always_comb begin
    push        = in_a_valid && in_a_ready;
    pop         = out_a_valid && out_a_ready;
    full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    empty       = (wr_ptr == rd_ptr);
    // Modulo-2*DEPTH subtraction yields 0..DEPTH without special cases.
    count       = wr_ptr - rd_ptr;
    wr_ptr_next = push ? (wr_ptr + ONE_P) : wr_ptr;
    rd_ptr_next = pop  ? (rd_ptr + ONE_P) : rd_ptr;
    count_next  = count + (push ? ONE_P : ZERO_P) - (pop ? ONE_P : ZERO_P);
  end

  // Pointer and handshake flag registers; ready rises on the first edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_a_ready  <= 1'b0;
      out_a_valid <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      in_a_ready  <= (count_next < DEPTH_P);
      out_a_valid <= (count_next != ZERO_P);
    end
  end

  // Head word is read from the slot the read pointer will point to next.
  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (in_a_data),
    .rd_addr (rd_ptr_next[AW-1:0]),
    .rd_data (out_a_data)
  );

`ifdef STREAM_FIFO_LEVEL_EN
  // Occupancy register, updated on the same edge as the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      level <= count_next;
    end
  end

  a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full))
    else $error("push while full");
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) !(pop && empty))
    else $error("pop while empty");
`else
  // Flags only feed the optional checks; keep them referenced.
  logic unused_flags;
  assign unused_flags = full ^ empty;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_fifo
//  Brief    : Directed self-checking bench for stream_fifo (DEPTH=4, 8-bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] in_a_data;
  logic       in_a_valid;
  logic       in_a_ready;
  logic [7:0] out_a_data;
  logic       out_a_valid;
  logic       out_a_ready;
`ifdef STREAM_FIFO_LEVEL_EN
  logic [2:0] level;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] q[$];

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_a_data   (in_a_data),
    .in_a_valid  (in_a_valid),
    .in_a_ready  (in_a_ready),
    .out_a_data  (out_a_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready)
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    .level       (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (in_a_ready !== 1'b0 || out_a_valid !== 1'b0 || out_a_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h, required 0 0 00", in_a_ready, out_a_valid, out_a_data);
    end
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if (in_a_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: ready=%b, required 0", in_a_ready);
    end
    tick();
    checks++;
    if (in_a_ready !== 1'b1 || out_a_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: ready=%b valid=%b, required 1 0", in_a_ready, out_a_valid);
    end
    // Push one word so out_a_valid is high, then reset asynchronously mid-cycle.
    in_a_data = 8'h77; in_a_valid = 1'b1;
    tick();
    in_a_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_a_ready !== 1'b0 || out_a_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: ready=%b valid=%b, required 0 0", in_a_ready, out_a_valid);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    out_a_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_a_data  = 8'(8'h11 * (i + 1));
      in_a_valid = 1'b1;
      tick();
      checks++;
      if (in_a_ready !== (i < 3) || out_a_valid !== 1'b1 || out_a_data !== 8'h11) begin
        failures++;
        $display("FAIL fill_%0d: ready=%b valid=%b data=%h, required %b 1 11", i, in_a_ready, out_a_valid, out_a_data, (i < 3));
      end
    end
    in_a_data = 8'h55;
    tick();
    in_a_valid = 1'b0;
    checks++;
    if (in_a_ready !== 1'b0 || out_a_data !== 8'h11) begin
      failures++;
      $display("FAIL full_reject: ready=%b data=%h, required 0 11", in_a_ready, out_a_data);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    out_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 8'(8'h11 * (i + 1));
      checks++;
      if (out_a_valid !== 1'b1 || out_a_data !== exp) begin
        failures++;
        $display("FAIL drain_%0d: valid=%b data=%h, required 1 %h", i, out_a_valid, out_a_data, exp);
      end
      tick();
      if (i == 0) begin
        checks++;
        if (in_a_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_after_pop: ready=%b, required 1", in_a_ready);
        end
      end
    end
    checks++;
    if (out_a_valid !== 1'b0) begin
      failures++;
      $display("FAIL drained_empty: valid=%b, required 0", out_a_valid);
    end
    out_a_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent;
    int errs = 0;
    out_a_ready = 1'b1;
    in_a_valid  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      sent      = 8'(k);
      in_a_data = sent;
      tick();
      checks++;
      if (in_a_ready !== 1'b1 || out_a_valid !== 1'b1 || out_a_data !== sent) begin
        failures++;
        errs++;
        $display("FAIL stream_%0d: ready=%b valid=%b data=%h, required 1 1 %h", k, in_a_ready, out_a_valid, out_a_data, sent);
      end
      if (errs > 3) break;
    end
    in_a_valid = 1'b0;
    tick();
    checks++;
    if (out_a_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: valid=%b, required 0", out_a_valid);
    end
    out_a_ready = 1'b0;
  endtask

  task automatic test_random();
    int popped = 0;
    int cyc = 0;
    int fail0 = failures;
    logic [7:0] nxt = 8'($urandom);
    q.delete();
    while (popped < 1000 && cyc < 20000 && failures == fail0) begin
      in_a_valid  = 1'($urandom_range(0, 1));
      out_a_ready = 1'($urandom_range(0, 1));
      in_a_data   = nxt;
      #1;
      if (out_a_valid && out_a_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_pop_empty: data=%h, required no valid word", out_a_data);
        end else begin
          if (out_a_data !== q[0]) begin
            failures++;
            $display("FAIL rand_data: word=%0d data=%h, required %h", popped, out_a_data, q[0]);
          end
          void'(q.pop_front());
        end
        popped++;
      end
      if (in_a_valid && in_a_ready) begin
        q.push_back(nxt);
        nxt = 8'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (out_a_valid !== (q.size() != 0) || in_a_ready !== (q.size() < 4)) begin
        failures++;
        $display("FAIL rand_flags: cycle=%0d valid=%b ready=%b, required %b %b", cyc, out_a_valid, in_a_ready, (q.size() != 0), (q.size() < 4));
      end
`ifdef STREAM_FIFO_LEVEL_EN
      checks++;
      if (level !== 3'(q.size())) begin
        failures++;
        $display("FAIL rand_level: cycle=%0d level=%0d, required %0d", cyc, level, q.size());
      end
`endif
    end
    checks++;
    if (failures == fail0 && popped < 1000) begin
      failures++;
      $display("FAIL rand_timeout: popped=%0d, required 1000", popped);
    end
    in_a_valid  = 1'b0;
    out_a_ready = 1'b1;
    repeat (5) tick();
    out_a_ready = 1'b0;
    q.delete();
  endtask

  task automatic test_reset_midstream();
    out_a_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_a_data  = 8'(i);
      in_a_valid = 1'b1;
      tick();
    end
    in_a_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_a_valid !== 1'b0 || in_a_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b ready=%b, required 0 0", out_a_valid, in_a_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_a_valid !== 1'b0 || in_a_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_release: valid=%b ready=%b, required 0 1", out_a_valid, in_a_ready);
    end
    in_a_data  = 8'hA5;
    in_a_valid = 1'b1;
    tick();
    in_a_valid = 1'b0;
    checks++;
    if (out_a_valid !== 1'b1 || out_a_data !== 8'hA5) begin
      failures++;
      $display("FAIL first_after_reset: valid=%b data=%h, required 1 a5", out_a_valid, out_a_data);
    end
    out_a_ready = 1'b1;
    tick();
    out_a_ready = 1'b0;
    checks++;
    if (out_a_valid !== 1'b0) begin
      failures++;
      $display("FAIL only_one_word: valid=%b, required 0", out_a_valid);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_a_data   = 8'h00;
    in_a_valid  = 1'b0;
    out_a_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Registered ready/valid FIFO sitting between a stream initiator and a stream responder.
- Consumes on the `in_a` side (acts as responder: samples `data`/`valid`, drives `ready`) and produces on the `out_a` side (acts as initiator: drives `data`/`valid`, samples `ready`).
- Breaks every combinational path between the two sides, so `ready` and `valid` chains do not cascade through the top level.
- Used as the standard elastic buffer on 8-bit stream links.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_a_data  input  DATA_WIDTH  upstream payload.
- in_a_valid  input  1  upstream payload valid.
- in_a_ready  output  1  FIFO can accept; registered.
- out_a_data  output  DATA_WIDTH  head-of-FIFO payload; registered.
- out_a_valid  output  1  head entry valid; registered.
- out_a_ready  input  1  downstream accepts.

Behaviour:
- Reset: one clock, `clk`; reset is asynchronous and active-high, on port `rst`. Asserting `rst` immediately forces:
  - `in_a_ready`=0, `out_a_valid`=0, `out_a_data`=0.
  - read/write pointers=0, count=0.
  - Storage array is not reset.
- Post-reset: `in_a_ready` rises on the first `clk` rising edge with `rst` low.
- Transfer rule:
  - Push when `in_a_valid && in_a_ready` at a rising edge.
  - Pop when `out_a_valid && out_a_ready` at a rising edge.
- `in_a_ready` = registered (count_next < DEPTH). It never depends combinationally on `out_a_ready`.
- `out_a_valid` = registered (count_next > 0). `out_a_data` is registered from storage at rd_ptr_next; it is stable while `out_a_valid` is high and unpopped.
- Latency: a word pushed at edge N is presented on `out_a` after edge N. Minimum fall-through is 1 cycle; there is no same-cycle bypass.
- Pointers: log2(DEPTH)+1 bits, with the MSB used as wrap bit.
  - full = (low bits equal) && (MSB differs).
  - empty = pointers equal.
  - Pointers wrap modulo 2*DEPTH without special-casing.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any fill level where both handshakes are true, including count=DEPTH with a pop (in_a_ready is already 0, so no push occurs).
- Full (count=DEPTH):
  - `in_a_ready`=0.
  - A pop at edge N raises `in_a_ready` after edge N.
- Empty:
  - `out_a_valid`=0, and `out_a_ready` is ignored.
  - A push at edge N raises `out_a_valid` after edge N.
- Upstream protocol: `in_a_valid` may drop without a handshake. The FIFO does not check stability; no push occurs unless `ready` is high.
- Reset mid-stream: all buffered words are discarded. No partial transfer is completed.
- Throughput: one word per cycle sustained in steady state for DEPTH >= 2.

Optional Feature:
- Macro `STREAM_FIFO_LEVEL_EN`.
- Defined:
  - Adds output port `level`, width log2(DEPTH)+1. It is the registered current count; reset 0; updates on the same edge as the pointers.
  - Adds an assertion block that flags a push while full or a pop while empty.
- Undefined:
  - The port and the assertions are absent.
  - Count is derived from the pointers internally only.

Decomposition:
- Package `stream_fifo_pkg`:
  - DATA_WIDTH default constant.
  - Pointer width function (clog2-based).
  - `stream_t` typedef struct {data, valid}, reused by other stream blocks.
- Sub-module `stream_fifo_mem`:
  - DEPTH x DATA_WIDTH register file.
  - One write port, one registered read port.
  - Write enable, write address, read address.
  - No reset on storage.
- Control, pointers and flags live in `stream_fifo`.

Test Plan:
1. Reset release → after first edge `in_a_ready`=1 and `out_a_valid`=0. Asserting `rst` asynchronously mid-cycle immediately drops both `in_a_ready` and `out_a_valid` to 0.
2. Push 0x11, 0x22, 0x33, 0x44 with `out_a_ready`=0 (DEPTH=4) → `in_a_ready`=0 after the 4th edge. A 5th offered word 0x55 is not accepted.
3. From full, `out_a_ready`=1 for 4 cycles → out sequence 0x11, 0x22, 0x33, 0x44. `in_a_ready` returns to 1 after the first pop. `out_a_valid`=0 after the last.
4. Continuous `in_a_valid`=1 and `out_a_ready`=1 with an incrementing 0x00..0xFF counter → one word per cycle. Output equals input delayed 1 cycle; no drops across multiple pointer wraps.
5. Random `valid`/`ready` throttling (50%) for 1000 words versus a scoreboard → order and data exact, no duplicates. With `STREAM_FIFO_LEVEL_EN`, `level` tracks the scoreboard count each cycle.
6. Assert `rst` with 3 entries buffered, then release → `out_a_valid`=0. The next pushed word 0xA5 is the first popped.
